// File: rtl/stack_cmd_scheduler_pkg.sv
// rtl/stack_cmd_scheduler_pkg.sv - shared types and defaults for the stack command scheduler
package stack_ctrl_pkg;

  // Scheduler FSM: IDLE arbitrates single requests, BURST runs the timed read-more pops
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  localparam int DATA_WIDTH_DEF  = 4;
  localparam int TICK_CYCLES_DEF = 100000000;
  localparam int TICK_CYCLES_SIM = 4;

endpackage

// File: rtl/stack_cmd_scheduler_if.sv
// rtl/stack_cmd_scheduler_if.sv - request/stack-core bundle between button edges, scheduler and stack
interface stack_cmd_if
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  push_edge;
  logic                  pop_edge;
  logic                  read_more_edge;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] stack_top;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  stk_push;
  logic                  stk_pop;
  logic [DATA_WIDTH-1:0] stk_wdata;
  logic                  busy;
  logic [DATA_WIDTH-1:0] burst_left;
  logic                  err_full;
  logic                  err_empty;

  // Requester / stack-status side
  modport master (
    output push_edge, pop_edge, read_more_edge, data_in, stack_top, stack_empty, stack_full,
    input  stk_push, stk_pop, stk_wdata, busy, burst_left, err_full, err_empty
  );

  // Scheduler side
  modport slave (
    input  push_edge, pop_edge, read_more_edge, data_in, stack_top, stack_empty, stack_full,
    output stk_push, stk_pop, stk_wdata, busy, burst_left, err_full, err_empty
  );

endinterface

// File: rtl/stack_cmd_scheduler_tick_gen.sv
// rtl/stack_cmd_scheduler_tick_gen.sv - burst pacing counter, pulses tick on its last count
module stack_tick_gen
  import stack_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_edge,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == CNT_LAST);

  // Clear wins; otherwise count while enabled and wrap to 0 on the tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stack_cmd_scheduler.sv
// rtl/stack_cmd_scheduler.sv - arbitrates push/pop/read-more and runs the timed pop burst
module stack_cmd_scheduler
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input logic        clk,
  input logic        rst_edge,
  stack_cmd_if.slave bus
);

  sched_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] burst_left_q, burst_left_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic                  err_full_q, err_full_d;
  logic                  err_empty_q, err_empty_d;
  logic                  tick_clear;
  logic                  tick;

  stack_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk     (clk),
    .rst_edge(rst_edge),
    .clear   (tick_clear),
    .enable  (state_q == BURST),
    .tick    (tick)
  );

  // Arbitration and burst sequencing; every strobe/error is registered for one cycle
  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;
    wdata_d      = wdata_q;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    err_full_d   = 1'b0;
    err_empty_d  = 1'b0;
    tick_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.read_more_edge) begin
          if (bus.stack_empty) begin
            err_empty_d = 1'b1;
          end else if (bus.stack_top != '0) begin
            // Top entry is only peeked as the count; it stays on the stack
            burst_left_d = bus.stack_top;
            tick_clear   = 1'b1;
            state_d      = BURST;
          end
        end else if (bus.pop_edge) begin
          if (bus.stack_empty) err_empty_d = 1'b1;
          else                 pop_d       = 1'b1;
        end else if (bus.push_edge) begin
          if (bus.stack_full) begin
            err_full_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            wdata_d = bus.data_in;
          end
        end
      end
      BURST: begin
        if (bus.read_more_edge) begin
          // Cancel outranks a coincident tick: no pop this cycle
          burst_left_d = '0;
          tick_clear   = 1'b1;
          state_d      = IDLE;
        end else if (tick) begin
          if (bus.stack_empty) begin
            err_empty_d  = 1'b1;
            burst_left_d = '0;
            state_d      = IDLE;
          end else begin
            pop_d        = 1'b1;
            burst_left_d = burst_left_q - 1'b1;
            if (burst_left_q == DATA_WIDTH'(1)) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      state_q      <= IDLE;
      burst_left_q <= '0;
      wdata_q      <= '0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      err_full_q   <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      wdata_q      <= wdata_d;
      push_q       <= push_d;
      pop_q        <= pop_d;
      err_full_q   <= err_full_d;
      err_empty_q  <= err_empty_d;
    end
  end

  assign bus.stk_push   = push_q;
  assign bus.stk_pop    = pop_q;
  assign bus.stk_wdata  = wdata_q;
  assign bus.busy       = (state_q == BURST);
  assign bus.burst_left = burst_left_q;
  assign bus.err_full   = err_full_q;
  assign bus.err_empty  = err_empty_q;

endmodule

// File: tb/tb_stack_cmd_scheduler.sv
// tb/tb_stack_cmd_scheduler.sv - self-checking bench for stack_cmd_scheduler
module tb_stack_cmd_scheduler;
  import stack_ctrl_pkg::*;

  localparam int DW = 4;
  localparam int T  = TICK_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst_edge;
  always #5 clk = ~clk;

  stack_cmd_if #(.DATA_WIDTH(DW)) bus ();

  stack_cmd_scheduler #(
    .DATA_WIDTH (DW),
    .TICK_CYCLES(T)
  ) dut (
    .clk     (clk),
    .rst_edge(rst_edge),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a burst is a count plus the absolute edge of the next due pop
  int n = 0;
  int base = 0;
  bit m_busy = 0;
  int m_left = 0;
  int m_next = 0;
  int m_wdata = 0;

  int pops[$];
  int ees[$];
  int left_hist[64];
  int busy_hist[64];

  typedef struct {
    bit pu, po, rm;
    int d, top;
    bit emp, ful;
    bit x_push, x_pop;
    int x_wdata;
    bit x_ef, x_ee, x_busy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_left = 0;
    m_next = 0;
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model
  task automatic cyc(input bit pu, input bit po, input bit rm, input int d, input int top,
                     input bit emp, input bit ful);
    bit ep, eo, ef, ee;
    int rel;
    ep = 0; eo = 0; ef = 0; ee = 0;
    bus.push_edge      = pu;
    bus.pop_edge       = po;
    bus.read_more_edge = rm;
    bus.data_in        = DW'(d);
    bus.stack_top      = DW'(top);
    bus.stack_empty    = emp;
    bus.stack_full     = ful;
    if (!m_busy) begin
      if (rm) begin
        if (emp) ee = 1;
        else if (top != 0) begin
          m_busy = 1; m_left = top; m_next = n + T;
        end
      end else if (po) begin
        if (emp) ee = 1; else eo = 1;
      end else if (pu) begin
        if (ful) ef = 1;
        else begin ep = 1; m_wdata = d; end
      end
    end else begin
      if (rm) begin
        m_busy = 0; m_left = 0;
      end else if (n == m_next) begin
        if (emp) begin
          ee = 1; m_busy = 0; m_left = 0;
        end else begin
          eo = 1; m_left--; m_next = n + T;
          if (m_left == 0) m_busy = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    rel = n - base;
    if (bus.stk_pop)   pops.push_back(rel);
    if (bus.err_empty) ees.push_back(rel);
    if (rel >= 0 && rel < 64) begin
      left_hist[rel] = int'(bus.burst_left);
      busy_hist[rel] = int'(bus.busy);
    end
    chk("stk_push", int'(bus.stk_push), int'(ep));
    chk("stk_pop", int'(bus.stk_pop), int'(eo));
    chk("err_full", int'(bus.err_full), int'(ef));
    chk("err_empty", int'(bus.err_empty), int'(ee));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("burst_left", int'(bus.burst_left), m_left);
    chk("push_pop_exclusive", int'(bus.stk_push & bus.stk_pop), 0);
    if (ep) chk("stk_wdata", int'(bus.stk_wdata), m_wdata);
    n++;
  endtask

  task automatic start_seq();
    base = n;
    pops.delete();
    ees.delete();
    for (int i = 0; i < 64; i++) begin
      left_hist[i] = -1;
      busy_hist[i] = -1;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_push"}, int'(bus.stk_push), 0);
    chk({tag, "_pop"}, int'(bus.stk_pop), 0);
    chk({tag, "_wdata"}, int'(bus.stk_wdata), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_left"}, int'(bus.burst_left), 0);
    chk({tag, "_err_full"}, int'(bus.err_full), 0);
    chk({tag, "_err_empty"}, int'(bus.err_empty), 0);
  endtask

  initial begin
    //          pu po rm d    top emp ful | push pop wdata ef ee busy
    tbl[0] = '{1, 0, 0, 'hA, 0,  0,  0,    1,   0,  'hA,  0, 0, 0};
    tbl[1] = '{0, 0, 0, 0,   0,  0,  0,    0,   0,  0,    0, 0, 0};
    tbl[2] = '{1, 1, 0, 'h3, 2,  0,  0,    0,   1,  0,    0, 0, 0};
    tbl[3] = '{0, 0, 0, 0,   0,  0,  0,    0,   0,  0,    0, 0, 0};
    tbl[4] = '{0, 1, 0, 0,   0,  1,  0,    0,   0,  0,    0, 1, 0};
    tbl[5] = '{1, 0, 0, 'h7, 0,  0,  1,    0,   0,  0,    1, 0, 0};
    tbl[6] = '{0, 0, 1, 0,   0,  0,  0,    0,   0,  0,    0, 0, 0};
    tbl[7] = '{0, 0, 1, 0,   6,  1,  0,    0,   0,  0,    0, 1, 0};
    tbl[8] = '{1, 1, 0, 'h9, 0,  1,  0,    0,   0,  0,    0, 1, 0};
    tbl[9] = '{1, 0, 0, 'h5, 0,  1,  0,    1,   0,  'h5,  0, 0, 0};

    bus.push_edge = 0; bus.pop_edge = 0; bus.read_more_edge = 0;
    bus.data_in = '0; bus.stack_top = '0; bus.stack_empty = 1; bus.stack_full = 0;
    rst_edge = 1;
    #2;
    chk_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_edge = 0;
    model_reset();

    // Single-cycle arbitration vectors, all from IDLE
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].pu, tbl[i].po, tbl[i].rm, tbl[i].d, tbl[i].top, tbl[i].emp, tbl[i].ful);
      chk($sformatf("vec%0d_push", i), int'(bus.stk_push), int'(tbl[i].x_push));
      chk($sformatf("vec%0d_pop", i), int'(bus.stk_pop), int'(tbl[i].x_pop));
      if (tbl[i].x_push) chk($sformatf("vec%0d_wdata", i), int'(bus.stk_wdata), tbl[i].x_wdata);
      chk($sformatf("vec%0d_err_full", i), int'(bus.err_full), int'(tbl[i].x_ef));
      chk($sformatf("vec%0d_err_empty", i), int'(bus.err_empty), int'(tbl[i].x_ee));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].x_busy));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Burst of 3, pop request mid-burst is ignored
    start_seq();
    cyc(0, 0, 1, 0, 3, 0, 0);
    for (int r = 1; r <= 15; r++) cyc(0, (r == 6), 0, 0, 3, 0, 0);
    chk("b3_pop_count", pops.size(), 3);
    if (pops.size() == 3) begin
      chk("b3_pop0_edge", pops[0], 4);
      chk("b3_pop1_edge", pops[1], 8);
      chk("b3_pop2_edge", pops[2], 12);
    end
    chk("b3_busy_at0", busy_hist[0], 1);
    chk("b3_left_at0", left_hist[0], 3);
    chk("b3_left_at4", left_hist[4], 2);
    chk("b3_left_at8", left_hist[8], 1);
    chk("b3_left_at12", left_hist[12], 0);
    chk("b3_busy_at11", busy_hist[11], 1);
    chk("b3_busy_at12", busy_hist[12], 0);

    // Burst of 5, stack drains before the third tick
    start_seq();
    cyc(0, 0, 1, 0, 5, 0, 0);
    for (int r = 1; r <= 14; r++) cyc(0, 0, 0, 0, 5, (r >= 9), 0);
    chk("b5_pop_count", pops.size(), 2);
    chk("b5_err_count", ees.size(), 1);
    if (ees.size() == 1) chk("b5_err_edge", ees[0], 12);
    chk("b5_busy_at12", busy_hist[12], 0);
    chk("b5_left_at12", left_hist[12], 0);

    // Cancel coinciding with the second tick
    start_seq();
    cyc(0, 0, 1, 0, 3, 0, 0);
    for (int r = 1; r <= 16; r++) cyc(0, 0, (r == 8), 0, 3, 0, 0);
    chk("cancel_pop_count", pops.size(), 1);
    if (pops.size() == 1) chk("cancel_pop_edge", pops[0], 4);
    chk("cancel_busy_at8", busy_hist[8], 0);
    chk("cancel_left_at8", left_hist[8], 0);

    // Asynchronous reset with the tick counter at 2
    start_seq();
    cyc(0, 0, 1, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 5, 0, 0);
    #3;
    rst_edge = 1;
    #1;
    chk_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    rst_edge = 0;
    model_reset();
    start_seq();
    for (int r = 0; r < 14; r++) cyc(0, 0, 0, 0, 5, 0, 0);
    chk("post_rst_pop_count", pops.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 15) == 0),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
